// File: rtl/inner_product_pkg.sv
// Shared state encoding, width helper and result narrowing for the inner-product MAC.
package inner_product_pkg;

   typedef logic [2:0] state_t;

   localparam state_t StIdle  = 3'd0;
   localparam state_t StLoad  = 3'd1;
   localparam state_t StMac   = 3'd2;
   localparam state_t StDrain = 3'd3;
   localparam state_t StDone  = 3'd4;

   // Working width for the narrowing helpers; AccW must not exceed it.
   localparam int unsigned WideW = 128;

   function automatic int unsigned acc_width(input int unsigned nbits, input int unsigned n);
      return 2 * nbits + $clog2(n) + 1;
   endfunction

   function automatic logic fits_signed(input logic signed [WideW-1:0] val,
                                        input int unsigned nbits);
      logic signed [WideW-1:0] max_v;
      logic signed [WideW-1:0] min_v;
      max_v = (128'sd1 <<< (nbits - 1)) - 128'sd1;
      min_v = -max_v - 128'sd1;
      return (val <= max_v) && (val >= min_v);
   endfunction

   // Clamp to the nbits signed range when sat_en, otherwise pass through; caller keeps low nbits.
   function automatic logic [WideW-1:0] narrow(input logic signed [WideW-1:0] val,
                                               input int unsigned nbits,
                                               input logic sat_en);
      logic signed [WideW-1:0] max_v;
      logic signed [WideW-1:0] min_v;
      max_v = (128'sd1 <<< (nbits - 1)) - 128'sd1;
      min_v = -max_v - 128'sd1;
      if (sat_en && (val > max_v)) begin
         return max_v;
      end else if (sat_en && (val < min_v)) begin
         return min_v;
      end
      return val;
   endfunction

endpackage

// File: rtl/inner_product_lane.sv
// One registered signed nBits x nBits multiplier; mask_i forces the registered product to zero.
module inner_product_lane #(
   parameter int unsigned nBits = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      mask_i,
   input  logic signed [nBits-1:0]   a_i,
   input  logic signed [nBits-1:0]   b_i,
   output logic signed [2*nBits-1:0] prod_o
);

   logic signed [2*nBits-1:0] a_ext;
   logic signed [2*nBits-1:0] b_ext;
   logic signed [2*nBits-1:0] prod_d;
   logic signed [2*nBits-1:0] prod_q;

   always_comb begin
      a_ext  = {{nBits{a_i[nBits-1]}}, a_i};
      b_ext  = {{nBits{b_i[nBits-1]}}, b_i};
      prod_d = mask_i ? '0 : a_ext * b_ext;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prod_q <= '0;
      end else begin
         prod_q <= prod_d;
      end
   end

   assign prod_o = prod_q;

endmodule

// File: rtl/inner_product_mac.sv
// Multi-lane fixed-point MAC: result = resetValue +/- sum(vector1[i]*vector2[i]), i = 0..M-1.
// Define INNER_PRODUCT_SAT_EN to saturate the result on overflow instead of wrapping.
module inner_product_mac
   import inner_product_pkg::*;
#(
   parameter int unsigned N        = 8,
   parameter int unsigned nBits    = 32,
   parameter int unsigned fracBits = 15,
   parameter int unsigned LANES    = 2
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [nBits*N-1:0] vector1_i,
   input  logic [nBits*N-1:0] vector2_i,
   input  logic [nBits-1:0]   reset_value_i,
   input  logic [31:0]        maximum_pos_i,
   input  logic               start_i,
   input  logic               add_subs_i,
   output logic               busy_o,
   output logic               endflag_o,
   output logic [nBits-1:0]   result_o,
   output logic               overflow_o
);

`ifdef INNER_PRODUCT_SAT_EN
   localparam logic SatEn = 1'b1;
`else
   localparam logic SatEn = 1'b0;
`endif

   localparam int unsigned AccW  = acc_width(nBits, N);
   localparam int unsigned ProdW = 2 * nBits;
   localparam int unsigned CntW  = $clog2(N) + 1;

   state_t                  state_q, state_d;
   logic [nBits*N-1:0]      v1_q, v2_q;
   logic [nBits-1:0]        rv_q;
   logic [CntW-1:0]         cnt_q, groups_q;
   logic [CntW-1:0]         grp_q, grp_d;
   logic                    add_q;
   logic signed [AccW-1:0]  acc_q, acc_d;
   logic                    busy_q, busy_d;
   logic                    end_q, end_d;
   logic [nBits-1:0]        result_q, result_d;
   logic                    ovf_q, ovf_d;

   logic                    accept;
   logic [CntW-1:0]         m_in;
   logic [CntW-1:0]         g_in;
   logic signed [AccW-1:0]  acc_init;
   logic signed [AccW-1:0]  lane_sum;
   logic signed [AccW-1:0]  acc_step;
   logic signed [AccW-1:0]  shifted;
   logic signed [WideW-1:0] wide;

   logic signed [nBits-1:0] op1 [LANES];
   logic signed [nBits-1:0] op2 [LANES];
   logic                    lane_en [LANES];
   logic signed [ProdW-1:0] prod [LANES];

   assign accept = start_i && ((state_q == StIdle) || (state_q == StDone));

   // maximum_pos_i < N here, so its low CntW bits carry the whole value.
   always_comb begin
      if (maximum_pos_i >= 32'(N)) begin
         m_in = CntW'(N);
      end else begin
         m_in = maximum_pos_i[CntW-1:0] + CntW'(1);
      end
      g_in = CntW'((32'(m_in) + LANES - 1) / LANES);
   end

   always_comb begin
      int unsigned idx;
      for (int unsigned l = 0; l < LANES; l++) begin
         idx        = 32'(grp_q) * LANES + l;
         op1[l]     = '0;
         op2[l]     = '0;
         lane_en[l] = (state_q == StMac) && (idx < 32'(cnt_q));
         for (int unsigned i = 0; i < N; i++) begin
            if (idx == i) begin
               op1[l] = v1_q[nBits*(N-i)-1 -: nBits];
               op2[l] = v2_q[nBits*(N-i)-1 -: nBits];
            end
         end
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      inner_product_lane #(
         .nBits (nBits)
      ) u_lane (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .mask_i (~lane_en[l]),
         .a_i    (op1[l]),
         .b_i    (op2[l]),
         .prod_o (prod[l])
      );
   end

   // Products registered outside MAC are zero, so summing them is harmless.
   always_comb begin
      lane_sum = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         lane_sum = lane_sum + {{(AccW-ProdW){prod[l][ProdW-1]}}, prod[l]};
      end
      acc_step = add_q ? (acc_q + lane_sum) : (acc_q - lane_sum);
      acc_init = {{(AccW-nBits){rv_q[nBits-1]}}, rv_q} <<< fracBits;
      shifted  = acc_step >>> fracBits;
      wide     = {{(WideW-AccW){shifted[AccW-1]}}, shifted};
   end

   always_comb begin
      state_d  = state_q;
      grp_d    = grp_q;
      acc_d    = acc_q;
      busy_d   = busy_q;
      end_d    = end_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      case (state_q)
         StIdle, StDone: begin
            if (accept) begin
               state_d = StLoad;
               busy_d  = 1'b1;
               end_d   = 1'b0;
            end
         end
         StLoad: begin
            acc_d   = acc_init;
            grp_d   = '0;
            state_d = StMac;
         end
         StMac: begin
            acc_d = acc_step;
            if (grp_q == groups_q - CntW'(1)) begin
               state_d = StDrain;
            end else begin
               grp_d = grp_q + CntW'(1);
            end
         end
         StDrain: begin
            acc_d    = acc_step;
            state_d  = StDone;
            busy_d   = 1'b0;
            end_d    = 1'b1;
            result_d = nBits'(narrow(wide, nBits, SatEn));
            ovf_d    = ~fits_signed(wide, nBits);
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         grp_q    <= '0;
         acc_q    <= '0;
         busy_q   <= 1'b0;
         end_q    <= 1'b0;
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         grp_q    <= grp_d;
         acc_q    <= acc_d;
         busy_q   <= busy_d;
         end_q    <= end_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
      end
   end

   // Operands are captured when a start is accepted and held for the whole operation.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v1_q     <= '0;
         v2_q     <= '0;
         rv_q     <= '0;
         cnt_q    <= '0;
         groups_q <= '0;
         add_q    <= 1'b0;
      end else if (accept) begin
         v1_q     <= vector1_i;
         v2_q     <= vector2_i;
         rv_q     <= reset_value_i;
         cnt_q    <= m_in;
         groups_q <= g_in;
         add_q    <= add_subs_i;
      end
   end

   assign busy_o     = busy_q;
   assign endflag_o  = end_q;
   assign result_o   = result_q;
   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_inner_product_mac.sv
// Directed bench for inner_product_mac: N=3 and N=8 instances, both with two lanes, Q17.15.
module tb_inner_product_mac;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [95:0]  a_v1, a_v2;
   logic [31:0]  a_rv, a_mp, a_res;
   logic         a_start, a_add, a_busy, a_end, a_ovf;

   logic [255:0] b_v1, b_v2;
   logic [31:0]  b_rv, b_mp, b_res;
   logic         b_start, b_add, b_busy, b_end, b_ovf;

   inner_product_mac #(
      .N (3), .nBits (32), .fracBits (15), .LANES (2)
   ) dut_a (
      .clk_i (clk), .rst_ni (rst_n), .vector1_i (a_v1), .vector2_i (a_v2),
      .reset_value_i (a_rv), .maximum_pos_i (a_mp), .start_i (a_start), .add_subs_i (a_add),
      .busy_o (a_busy), .endflag_o (a_end), .result_o (a_res), .overflow_o (a_ovf)
   );

   inner_product_mac #(
      .N (8), .nBits (32), .fracBits (15), .LANES (2)
   ) dut_b (
      .clk_i (clk), .rst_ni (rst_n), .vector1_i (b_v1), .vector2_i (b_v2),
      .reset_value_i (b_rv), .maximum_pos_i (b_mp), .start_i (b_start), .add_subs_i (b_add),
      .busy_o (b_busy), .endflag_o (b_end), .result_o (b_res), .overflow_o (b_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Q15 constants; element 0 sits in the MSBs.
   localparam logic [95:0] V123 = {32'h0000_8000, 32'h0001_0000, 32'h0001_8000};
   localparam logic [95:0] V456 = {32'h0002_0000, 32'h0002_8000, 32'h0003_0000};

   task automatic run_a(input logic [95:0] v1, input logic [95:0] v2, input logic [31:0] rv,
                        input logic [31:0] mp, input logic add, output int lat);
      @(negedge clk);
      a_v1 = v1; a_v2 = v2; a_rv = rv; a_mp = mp; a_add = add; a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      lat = 0;
      while (a_end !== 1'b1 && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      if (lat >= 64) begin
         checks++; errors++;
         $display("FAIL run_a_timeout: endflag=%b after %0d cycles, required 1", a_end, lat);
      end
   endtask

   task automatic run_b(input logic [255:0] v1, input logic [255:0] v2, input logic [31:0] rv,
                        input logic [31:0] mp, input logic add, output int lat);
      @(negedge clk);
      b_v1 = v1; b_v2 = v2; b_rv = rv; b_mp = mp; b_add = add; b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      lat = 0;
      while (b_end !== 1'b1 && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      if (lat >= 64) begin
         checks++; errors++;
         $display("FAIL run_b_timeout: endflag=%b after %0d cycles, required 1", b_end, lat);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_v1 = '0; a_v2 = '0; a_rv = '0; a_mp = '0; a_start = 1'b0; a_add = 1'b0;
      b_v1 = '0; b_v2 = '0; b_rv = '0; b_mp = '0; b_start = 1'b0; b_add = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({a_busy, a_end, a_ovf} !== 3'b000) begin
         errors++; $display("FAIL reset_a_flags: got %b, required 000", {a_busy, a_end, a_ovf});
      end
      checks++;
      if (a_res !== 32'h0) begin
         errors++; $display("FAIL reset_a_result: got %h, required 00000000", a_res);
      end
      checks++;
      if ({b_busy, b_end, b_ovf, b_res} !== 35'h0) begin
         errors++; $display("FAIL reset_b_outputs: got %h, required 0", {b_busy, b_end, b_ovf, b_res});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int lat;
      run_a(V123, V456, 32'h0, 32'd2, 1'b1, lat);
      checks++;
      if (a_res !== 32'h0010_0000) begin
         errors++; $display("FAIL basic_result: got %h, required 00100000", a_res);
      end
      checks++;
      if (lat !== 4) begin
         errors++; $display("FAIL basic_latency: got %0d, required 4", lat);
      end
      checks++;
      if ({a_ovf, a_busy} !== 2'b00) begin
         errors++; $display("FAIL basic_ovf_busy: got %b, required 00", {a_ovf, a_busy});
      end
   endtask

   // New start clears endflag at once; the old result stays until the new completion.
   task automatic test_partial_and_hold();
      int lat;
      @(negedge clk);
      a_v1 = V123; a_v2 = V456; a_rv = 32'h0; a_mp = 32'd1; a_add = 1'b1; a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      checks++;
      if ({a_busy, a_end, a_res} !== {2'b10, 32'h0010_0000}) begin
         errors++;
         $display("FAIL hold_after_start: busy/end/result %b%b %h, required 10 00100000",
                  a_busy, a_end, a_res);
      end
      lat = 0;
      while (a_end !== 1'b1 && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (a_res !== 32'h0007_0000) begin
         errors++; $display("FAIL partial_result: got %h, required 00070000", a_res);
      end
      checks++;
      if (lat !== 3) begin
         errors++; $display("FAIL partial_latency: got %0d, required 3", lat);
      end
   endtask

   task automatic test_subtract();
      int lat;
      run_a(V123, V456, 32'h000F_8000, 32'd2, 1'b0, lat);
      checks++;
      if (a_res !== 32'hFFFF_8000) begin
         errors++; $display("FAIL subtract_result: got %h, required ffff8000", a_res);
      end
      checks++;
      if (a_ovf !== 1'b0) begin
         errors++; $display("FAIL subtract_ovf: got %b, required 0", a_ovf);
      end
   endtask

   task automatic test_single_and_clamp();
      int lat;
      run_a({32'h0000_4000, 32'h0003_8000, 32'h0004_8000},
            {32'hFFFF_C000, 32'h0001_8000, 32'h0001_0000}, 32'h0, 32'd0, 1'b1, lat);
      checks++;
      if (a_res !== 32'hFFFF_E000) begin
         errors++; $display("FAIL single_result: got %h, required ffffe000", a_res);
      end
      checks++;
      if (lat !== 3) begin
         errors++; $display("FAIL single_latency: got %0d, required 3", lat);
      end
      run_a(V123, V456, 32'h0, 32'd40, 1'b1, lat);
      checks++;
      if (a_res !== 32'h0010_0000) begin
         errors++; $display("FAIL clamp_result: got %h, required 00100000", a_res);
      end
      checks++;
      if (lat !== 4) begin
         errors++; $display("FAIL clamp_latency: got %0d, required 4", lat);
      end
   endtask

   task automatic test_overflow();
      int lat;
      logic [31:0] exp_res;
`ifdef INNER_PRODUCT_SAT_EN
      exp_res = 32'h7FFF_FFFF;
`else
      exp_res = 32'h7100_0000;
`endif
      run_b({8{32'h0064_0000}}, {8{32'h0064_0000}}, 32'h0, 32'd7, 1'b1, lat);
      checks++;
      if (b_res !== exp_res) begin
         errors++; $display("FAIL overflow_result: got %h, required %h", b_res, exp_res);
      end
      checks++;
      if (b_ovf !== 1'b1) begin
         errors++; $display("FAIL overflow_flag: got %b, required 1", b_ovf);
      end
      checks++;
      if (lat !== 6) begin
         errors++; $display("FAIL overflow_latency: got %0d, required 6", lat);
      end
   endtask

   task automatic test_odd_group();
      int lat;
      logic [255:0] v;
      v = {32'h0000_8000, 32'h0001_0000, 32'h0001_8000, 32'h0002_0000,
           32'h0002_8000, 32'h0003_0000, 32'h0003_8000, 32'h0004_0000};
      run_b(v, v, 32'h0, 32'd4, 1'b1, lat);
      checks++;
      if (b_res !== 32'h001B_8000) begin
         errors++; $display("FAIL odd_group_result: got %h, required 001b8000", b_res);
      end
      checks++;
      if ({lat, b_ovf} !== {32'd5, 1'b0}) begin
         errors++; $display("FAIL odd_group_lat_ovf: got %0d/%b, required 5/0", lat, b_ovf);
      end
   endtask

   // Start pulses and operand changes during the operation must not disturb it.
   task automatic test_busy_start();
      int lat;
      @(negedge clk);
      a_v1 = V123; a_v2 = V456; a_rv = 32'h0; a_mp = 32'd2; a_add = 1'b1; a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      @(posedge clk); #1;
      a_v1 = V456; a_v2 = V456; a_rv = 32'h000F_8000; a_add = 1'b0; a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      lat = 2;
      while (a_end !== 1'b1 && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (a_res !== 32'h0010_0000) begin
         errors++; $display("FAIL busy_start_result: got %h, required 00100000", a_res);
      end
      checks++;
      if (lat !== 4) begin
         errors++; $display("FAIL busy_start_latency: got %0d, required 4", lat);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({a_busy, a_end, a_res} !== {2'b01, 32'h0010_0000}) begin
         errors++;
         $display("FAIL busy_start_idle: busy/end/result %b%b %h, required 01 00100000",
                  a_busy, a_end, a_res);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      @(negedge clk);
      b_v1 = {8{32'h0064_0000}}; b_v2 = {8{32'h0001_0000}}; b_rv = 32'h0; b_mp = 32'd7;
      b_add = 1'b1; b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({b_busy, b_end, b_ovf, b_res} !== 35'h0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got %h, required 0", {b_busy, b_end, b_ovf, b_res});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({b_busy, b_end, b_res} !== 34'h0) begin
         errors++;
         $display("FAIL reset_mid_stays_idle: got %h, required 0", {b_busy, b_end, b_res});
      end
      run_b({V123, 160'h0}, {V456, 160'h0}, 32'h0, 32'd2, 1'b1, lat);
      checks++;
      if (b_res !== 32'h0010_0000) begin
         errors++; $display("FAIL reset_mid_rerun: got %h, required 00100000", b_res);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_partial_and_hold();
      test_subtract();
      test_single_and_clamp();
      test_overflow();
      test_odd_group();
      test_busy_start();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/inner_product_mac.md
# inner_product_mac

Multi-lane fixed-point inner-product engine computing `result = resetValue ± Σ vector1[i]·vector2[i]` for i = 0..maximumPos. It processes LANES element pairs per cycle through a registered multiply stage, keeps a full-precision accumulator, and returns a Qm.f result with an overflow flag. It sits in the pseudoinverse datapath wherever dot products and residual updates are needed, and adds lane parallelism, operand capture, a busy/end handshake and overflow detection.

## Interface
- N, 8, maximum vector length (elements)
- nBits, 32, element and result width, signed fixed point
- fracBits, 15, fractional bits of every operand and of result
- LANES, 2, element pairs multiplied per cycle (1..N)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- vector1  in  nBits*N  element i at bits [nBits*(N-i)-1 : nBits*(N-i-1)] (element 0 in the MSBs)
- vector2  in  nBits*N  same packing as vector1
- resetValue  in  nBits  initial accumulator value, Q format
- maximumPos  in  32  index of last element used (inclusive); values ≥ N are clamped to N-1
- start  in  1  request, sampled in IDLE or DONE
- addSubs  in  1  1: add products, 0: subtract products from resetValue
- busy  out  1  high from accepted start until completion
- endflag  out  1  high in DONE, cleared by next accepted start
- result  out  nBits  signed Q result, held stable in DONE
- overflow  out  1  final sum outside nBits signed range

## Operation
- States: IDLE → LOAD → MAC → DRAIN → DONE; DONE → LOAD on start; any state → IDLE on reset.
- LOAD: capture vector1, vector2, resetValue, clamped count M = min(maximumPos,N-1)+1, addSubs; inputs may change afterward. Accumulator = sign-extended resetValue << fracBits. Group counter = 0; G = ceil(M/LANES).
- MAC: each cycle, group g presents elements g·LANES .. g·LANES+LANES-1; indices ≥ M or ≥ N are masked to zero. Full 2·nBits signed products are registered, then summed across the lanes and added or subtracted per addSubs. The state advances after group G-1 is issued.
- DRAIN: the last registered products are accumulated.
- DONE: result = acc >>> fracBits (arithmetic shift, truncation toward −∞), narrowed to nBits. overflow = the shifted value does not fit in nBits signed.
- Accumulator width: 2·nBits + clog2(N) + 1. No intermediate overflow is possible.
- start in LOAD/MAC/DRAIN is ignored. start in IDLE or DONE is accepted.

## Timing
- Reset values: busy=0, endflag=0, result=0, overflow=0, state IDLE, accumulator 0.
- Start sampled at edge 0. busy rises after edge 0. endflag rises and result/overflow become valid after edge G+2. busy falls on that same edge.
- Latency = G+2 cycles: M=3, LANES=2 gives 4 cycles. M=1 gives 3 cycles.
- Accepted start clears endflag after the same edge. result holds its old value until the new completion.
- Reset mid-operation aborts immediately. All outputs return to their reset values, and there is no partial result.

## Configuration
- INNER_PRODUCT_SAT_EN defined: on overflow, result saturates to 2^(nBits-1)-1 or -2^(nBits-1).
- INNER_PRODUCT_SAT_EN undefined: result takes the low nBits of the shifted accumulator (wrap).
- overflow behaves identically in both builds.

## Structure
- Package inner_product_pkg:
  - state enum
  - accumulator-width constant function
  - saturate/narrow function
- One sub-module, inner_product_lane: one registered signed nBits×nBits multiplier with a mask input, instantiated LANES times.

## Test plan
- N=3, LANES=2, Q17.15; vector1=(1,2,3), vector2=(4,5,6), maximumPos=2, resetValue=0, addSubs=1 → result 0x00100000 (32.0), endflag 4 cycles after start, overflow=0.
- Same vectors, maximumPos=1 → result 0x00070000 (14.0), latency 3 cycles.
- resetValue=31.0, addSubs=0, maximumPos=2 → result 0xFFFF8000 (−1.0).
- N=8, all elements 200.0, maximumPos=7:
  - with INNER_PRODUCT_SAT_EN → result 0x7FFFFFFF, overflow=1
  - without → result 0x71000000, overflow=1
- (0.5)·(−0.5), maximumPos=0 → 0xFFFFE000. maximumPos=40 with N=3 behaves as maximumPos=2.
- Pulse start while busy → ignored, original result unchanged. Assert reset at the second MAC cycle → outputs 0, IDLE; next start computes correctly.
